cccd_s00_axi_regfile: RTL

//  AXI4-Lite slave register file on the S00_AXI port of the cccd core; the responder end of the master VIP traffic.

---
 rtl/cccd_s00_axi_regfile.sv | 265 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/cccd_s00_axi_regfile.sv
// AXI4-Lite slave register file for the cccd core S00_AXI port.
// NUM_REGS 32-bit read/write registers at word offsets; contents are exported
// on reg_out and a one-cycle wr_pulse marks each committed write.
// Write and read channels run independently, one transaction outstanding each.
module cccd_s00_axi_regfile #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int NUM_REGS           = 4
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                      s00_axi_awprot,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                      s00_axi_arprot,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
  output logic [32*NUM_REGS-1:0]          reg_out,
  output logic [NUM_REGS-1:0]             wr_pulse
);

  localparam int IDXW = C_S_AXI_ADDR_WIDTH - 2;
  localparam int DW   = C_S_AXI_DATA_WIDTH;
  localparam int NB   = C_S_AXI_DATA_WIDTH / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_WAIT_W, W_WAIT_A, W_RESP} wstate_e;
  typedef enum logic       {R_IDLE, R_DATA} rstate_e;

  // Write channel state
  wstate_e         w_state_q, w_state_d;
  logic            awready_q, awready_d;
  logic            wready_q, wready_d;
  logic            bvalid_q, bvalid_d;
  logic [1:0]      bresp_q, bresp_d;
  logic [IDXW-1:0] aw_idx_q, aw_idx_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [NB-1:0]   wstrb_q, wstrb_d;
  logic [NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;

  // Commit request produced by the write FSM
  logic            commit;
  logic [IDXW-1:0] commit_idx;
  logic [DW-1:0]   commit_data;
  logic [NB-1:0]   commit_strb;

  // Read channel state
  rstate_e         r_state_q, r_state_d;
  logic            arready_q, arready_d;
  logic            rvalid_q, rvalid_d;
  logic [1:0]      rresp_q, rresp_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [DW-1:0]   rd_mux;

  logic [DW-1:0]   regs_q [NUM_REGS];

  logic aw_hs, w_hs, ar_hs;
  logic [IDXW-1:0] aw_idx_in, ar_idx_in;

  // Protection bits and byte-offset address bits carry no meaning here.
  logic unused_inputs;
  assign unused_inputs = ^{s00_axi_awprot, s00_axi_arprot,
                           s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  assign aw_hs     = s00_axi_awvalid & awready_q;
  assign w_hs      = s00_axi_wvalid  & wready_q;
  assign ar_hs     = s00_axi_arvalid & arready_q;
  assign aw_idx_in = s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
  assign ar_idx_in = s00_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2];

  function automatic logic idx_valid(input logic [IDXW-1:0] idx);
    return int'({1'b0, idx}) < NUM_REGS;
  endfunction

  // Write FSM next state: collects AW and W in either order, then commits.
  always_comb begin
    w_state_d   = w_state_q;
    aw_idx_d    = aw_idx_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    bvalid_d    = bvalid_q;
    bresp_d     = bresp_q;
    commit      = 1'b0;
    commit_idx  = aw_idx_q;
    commit_data = wdata_q;
    commit_strb = wstrb_q;
    unique case (w_state_q)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          commit      = 1'b1;
          commit_idx  = aw_idx_in;
          commit_data = s00_axi_wdata;
          commit_strb = s00_axi_wstrb;
          w_state_d   = W_RESP;
        end else if (aw_hs) begin
          aw_idx_d  = aw_idx_in;
          w_state_d = W_WAIT_W;
        end else if (w_hs) begin
          wdata_d   = s00_axi_wdata;
          wstrb_d   = s00_axi_wstrb;
          w_state_d = W_WAIT_A;
        end
      end
      W_WAIT_W: begin
        if (w_hs) begin
          commit      = 1'b1;
          commit_idx  = aw_idx_q;
          commit_data = s00_axi_wdata;
          commit_strb = s00_axi_wstrb;
          w_state_d   = W_RESP;
        end
      end
      W_WAIT_A: begin
        if (aw_hs) begin
          commit      = 1'b1;
          commit_idx  = aw_idx_in;
          commit_data = wdata_q;
          commit_strb = wstrb_q;
          w_state_d   = W_RESP;
        end
      end
      W_RESP: begin
        if (s00_axi_bready) begin
          bvalid_d  = 1'b0;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
    if (commit) begin
      bvalid_d = 1'b1;
      bresp_d  = idx_valid(commit_idx) ? RESP_OKAY : RESP_SLVERR;
    end
    // Ready flags are registered, so derive them from the next state.
    awready_d  = (w_state_d == W_IDLE) || (w_state_d == W_WAIT_A);
    wready_d   = (w_state_d == W_IDLE) || (w_state_d == W_WAIT_W);
    wr_pulse_d = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (commit && (commit_idx == IDXW'(i))) wr_pulse_d[i] = 1'b1;
    end
  end

  // Write FSM and write-response registers.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      w_state_q  <= W_IDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= '0;
      aw_idx_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      wr_pulse_q <= '0;
    end else begin
      w_state_q  <= w_state_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      aw_idx_q   <= aw_idx_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      wr_pulse_q <= wr_pulse_d;
    end
  end

  // Register array: byte-lane masked update on commit; out-of-range index writes nothing.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (commit) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        for (int unsigned b = 0; b < NB; b++) begin
          if ((commit_idx == IDXW'(i)) && commit_strb[b]) begin
            regs_q[i][8*b +: 8] <= commit_data[8*b +: 8];
          end
        end
      end
    end
  end

  // Read mux over implemented registers; unimplemented indices read as zero.
  always_comb begin
    rd_mux = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (ar_idx_in == IDXW'(i)) rd_mux = regs_q[i];
    end
  end

  // Read FSM next state: capture on AR handshake, hold until R handshake.
  always_comb begin
    r_state_d = r_state_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    unique case (r_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          r_state_d = R_DATA;
          rvalid_d  = 1'b1;
          rresp_d   = idx_valid(ar_idx_in) ? RESP_OKAY : RESP_SLVERR;
          rdata_d   = rd_mux;
        end
      end
      R_DATA: begin
        if (s00_axi_rready) begin
          r_state_d = R_IDLE;
          rvalid_d  = 1'b0;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    arready_d = (r_state_d == R_IDLE);
  end

  // Read FSM and read-data registers.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= '0;
      rdata_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

  // Flatten register array onto the core-facing bus.
  always_comb begin
    reg_out = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) reg_out[32*i +: 32] = regs_q[i];
  end

  assign s00_axi_awready = awready_q;
  assign s00_axi_wready  = wready_q;
  assign s00_axi_bvalid  = bvalid_q;
  assign s00_axi_bresp   = bresp_q;
  assign s00_axi_arready = arready_q;
  assign s00_axi_rvalid  = rvalid_q;
  assign s00_axi_rresp   = rresp_q;
  assign s00_axi_rdata   = rdata_q;
  assign wr_pulse        = wr_pulse_q;

endmodule
